// File: rtl/dot_product_acc.sv
// Dot-product accumulator: sums each group of LEN unsigned products
// and presents the wrapped sum with a sticky overflow flag.
module dot_product_acc #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 10,
  parameter int LEN    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int SUM_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic               out_valid_q;
  logic [ACC_W-1:0]   out_sum_q;
  logic               out_ovf_q;

  logic [SUM_W-1:0]   sum_w;
  logic [ACC_W-1:0]   acc_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               carry;
  logic               xfer;

  // Wide add so the carry out of the accumulator MSB is visible.
  always_comb begin
    sum_w = SUM_W'(acc_q) + SUM_W'(prod);
    acc_d = sum_w[ACC_W-1:0];
    carry = |(sum_w >> ACC_W);
    cnt_d = cnt_q + CNT_W'(1);
    xfer  = in_valid && (state_q == ACCUM);
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

  // Group FSM: accumulate LEN transfers, then hold the result until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else if (clear) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (xfer) begin
            if (cnt_q == LAST) begin
              out_sum_q   <= acc_d;
              out_ovf_q   <= ovf_q | carry;
              out_valid_q <= 1'b1;
              acc_q       <= '0;
              cnt_q       <= '0;
              ovf_q       <= 1'b0;
              state_q     <= HOLD;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_d;
              ovf_q <= ovf_q | carry;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_acc.sv
// Directed scoreboard bench for dot_product_acc (default, ACC_W=8
// and LEN=1 instances).
module tb_dot_product_acc;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic [7:0] prod;
  logic       out_ready;
  logic       in_ready;
  logic       out_valid;
  logic [9:0] out_sum;
  logic       out_ovf;

  logic       in_ready8;
  logic       out_valid8;
  logic [7:0] out_sum8;
  logic       out_ovf8;

  logic       in_valid1;
  logic [7:0] prod1;
  logic       out_ready1;
  logic       in_ready1;
  logic       out_valid1;
  logic [9:0] out_sum1;
  logic       out_ovf1;

  int checks;
  int failures;
  int msum;
  int mcnt;

  logic [10:0] q[$];
  logic [8:0]  q8[$];
  logic [10:0] q1[$];

  dot_product_acc dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .prod(prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );

  dot_product_acc #(.ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready8), .prod(prod),
    .out_valid(out_valid8), .out_ready(out_ready),
    .out_sum(out_sum8), .out_ovf(out_ovf8)
  );

  dot_product_acc #(.LEN(1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid1), .in_ready(in_ready1), .prod(prod1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_ovf(out_ovf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] p);
    int b;
    b = 0;
    while (!in_ready && b < 20) begin
      step();
      b++;
    end
    if (b == 20) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    prod     = p;
    step();
    in_valid = 1'b0;
    msum += int'(p);
    mcnt++;
    if (mcnt == 4) begin
      q.push_back({(msum > 1023), 10'(msum)});
      q8.push_back({(msum > 255), 8'(msum)});
      msum = 0;
      mcnt = 0;
    end
  endtask

  task automatic take(input int hold);
    int b;
    logic [10:0] e;
    logic [8:0]  e8;
    b = 0;
    while (!out_valid && b < 20) begin
      step();
      b++;
    end
    chk("out_valid_wait", 32'(out_valid), 32'd1);
    if (q.size() == 0 || q8.size() == 0) begin
      chk("scoreboard_empty", 32'(q.size()), 32'd1);
    end else begin
      e  = q.pop_front();
      e8 = q8.pop_front();
      chk("sum", 32'(out_sum), 32'(e[9:0]));
      chk("ovf", 32'(out_ovf), 32'(e[10]));
      chk("valid8", 32'(out_valid8), 32'd1);
      chk("sum8", 32'(out_sum8), 32'(e8[7:0]));
      chk("ovf8", 32'(out_ovf8), 32'(e8[8]));
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        prod     = 8'd99;
        step();
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_ready", 32'(in_ready), 32'd0);
        chk("hold_sum", 32'(out_sum), 32'(e[9:0]));
      end
      in_valid  = 1'b0;
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    logic [10:0] e1;
    checks     = 0;
    failures   = 0;
    msum       = 0;
    mcnt       = 0;
    rst        = 1'b1;
    clear      = 1'b0;
    in_valid   = 1'b0;
    prod       = '0;
    out_ready  = 1'b0;
    in_valid1  = 1'b0;
    prod1      = '0;
    out_ready1 = 1'b0;

    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(out_sum), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    step();

    // 1: basic group, back to back
    send(8'd10);
    send(8'd20);
    send(8'd30);
    send(8'd40);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_ready", 32'(in_ready), 32'd0);
    take(0);

    // 2: 225 x4, wraps in the ACC_W=8 instance
    repeat (4) send(8'd225);
    take(0);

    // 3: long hold with ignored input pulses
    send(8'd3);
    send(8'd5);
    send(8'd7);
    send(8'd11);
    take(5);
    send(8'd1);
    send(8'd2);
    send(8'd3);
    send(8'd4);
    take(0);

    // 4: clear drops a same-cycle product
    send(8'd5);
    send(8'd7);
    clear    = 1'b1;
    in_valid = 1'b1;
    prod     = 8'd9;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    msum     = 0;
    mcnt     = 0;
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_keep_sum", 32'(out_sum), 32'd10);
    send(8'd1);
    send(8'd2);
    send(8'd3);
    send(8'd4);
    take(0);

    // 5: async reset between edges
    send(8'd50);
    send(8'd60);
    send(8'd70);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_sum", 32'(out_sum), 32'd0);
    chk("arst_ovf", 32'(out_ovf), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    #1;
    rst  = 1'b0;
    msum = 0;
    mcnt = 0;
    step();
    repeat (4) send(8'd1);
    take(0);

    // 6: LEN=1, streaming with out_ready held high
    n          = 0;
    in_valid1  = 1'b1;
    out_ready1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      prod1 = 8'(i * 17 + 3);
      if (in_ready1) q1.push_back({3'b000, prod1});
      step();
      if (out_valid1) begin
        n++;
        if (q1.size() == 0) begin
          chk("len1_empty", 32'(q1.size()), 32'd1);
        end else begin
          e1 = q1.pop_front();
          chk("len1_sum", 32'(out_sum1), 32'(e1[9:0]));
          chk("len1_ovf", 32'(out_ovf1), 32'(e1[10]));
        end
      end
    end
    in_valid1  = 1'b0;
    out_ready1 = 1'b0;
    chk("len1_count", 32'(n), 32'd5);
    chk("len1_drain", 32'(q1.size()), 32'd0);
    chk("main_drain", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
